// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state and bit-slot phase
// encodings, plus the bus-level constants for direction and acknowledge.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_NACK,
        ST_STOP
    } i2c_state_e;

    // Quarter of a bit slot; each lasts CLK_DIV system clocks.
    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } i2c_phase_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bit_timer.sv
// Bit-slot timer for the I2C master. Divides clk into SCL quarter periods
// and walks the phase P0..P3 while run_i is high; held cleared otherwise.
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   run_i           count enable (FSM not idle)
//   phase_o         current quarter of the bit slot
//   slot_end_o      high in the last clk cycle of a bit slot
//   quarter_start_o high in the first clk cycle of every quarter
module i2c_bit_timer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    output i2c_phase_e phase_o,
    output logic       slot_end_o,
    output logic       quarter_start_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    i2c_phase_e    phase_q;
    logic          quarter_end;

    assign quarter_end = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            cnt_q   <= '0;
            phase_q <= PH_P0;
        end else if (quarter_end) begin
            cnt_q   <= '0;
            phase_q <= i2c_phase_e'(phase_q + 2'd1);
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign phase_o         = phase_q;
    assign slot_end_o      = run_i && quarter_end && (phase_q == PH_P3);
    assign quarter_start_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/i2c_master.sv
// Byte-oriented I2C master: one START, 7-bit address + R/W, one data byte
// (write or read), STOP. Open-drain SCL/SDA, no clock stretching.
//   clk      system clock
//   rst      synchronous active-high reset
//   start    request pulse, sampled only while idle
//   rw       direction captured with start (0 write, 1 read)
//   addr     7-bit target address captured with start
//   wdata    write byte captured with start
//   rdata    byte received by the last completed read
//   busy     transaction in progress
//   done     one-cycle pulse at transaction end
//   ack_err  a responder ACK was sampled high; valid with done
//   scl      open-drain clock (0 or z)
//   sda      open-drain data (0 or z), read back through the pad
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output wire        scl,
    inout  wire        sda
);

    i2c_state_e state_q;
    i2c_phase_e phase;
    logic       slot_end;
    logic       quarter_start;
    logic       sample;
    logic       timer_run;
    logic       sda_in;

    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       rw_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_err_q;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;

    assign timer_run = (state_q != ST_IDLE);

    i2c_bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk_i          (clk),
        .rst_i          (rst),
        .run_i          (timer_run),
        .phase_o        (phase),
        .slot_end_o     (slot_end),
        .quarter_start_o(quarter_start)
    );

    // SDA is sampled once per slot, at the first cycle of the SCL-high quarter.
    assign sample = quarter_start && (phase == PH_P2);
    assign sda_in = sda;

    // Line pull-down requests for the current state/phase; registered below so
    // the pins never glitch on decode transitions.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_q)
            ST_START: begin
                scl_oe_d = (phase == PH_P3);
                sda_oe_d = (phase inside {PH_P2, PH_P3});
            end
            ST_ADDR, ST_WRITE: begin
                scl_oe_d = (phase inside {PH_P0, PH_P3});
                sda_oe_d = ~shift_q[7];
            end
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_READ_NACK: begin
                scl_oe_d = (phase inside {PH_P0, PH_P3});
            end
            ST_STOP: begin
                scl_oe_d = (phase == PH_P0);
                sda_oe_d = (phase inside {PH_P0, PH_P1});
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rw_q      <= I2C_RW_WRITE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;

            if (sample && (state_q inside {ST_ADDR_ACK, ST_WRITE_ACK}) && (sda_in == I2C_NACK))
                ack_err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    // done_q is still high in the cycle right after STOP; a
                    // request in that cycle is dropped.
                    if (start && !done_q) begin
                        state_q   <= ST_START;
                        busy_q    <= 1'b1;
                        ack_err_q <= 1'b0;
                        rw_q      <= rw;
                        shift_q   <= {addr, rw};
                        wdata_q   <= wdata;
                        bit_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (slot_end) state_q <= ST_ADDR;
                end
                ST_ADDR, ST_WRITE: begin
                    if (slot_end) begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_q <= (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    // ack_err_q was cleared at accept, so here it reflects
                    // only this slot's sample.
                    if (slot_end) begin
                        if (ack_err_q) begin
                            state_q <= ST_STOP;
                        end else if (rw_q == I2C_RW_READ) begin
                            state_q <= ST_READ;
                        end else begin
                            shift_q <= wdata_q;
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (slot_end) state_q <= ST_STOP;
                end
                ST_READ: begin
                    if (sample) shift_q <= {shift_q[6:0], sda_in};
                    if (slot_end) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rdata_q <= shift_q;
                            state_q <= ST_READ_NACK;
                        end
                    end
                end
                ST_READ_NACK: begin
                    if (slot_end) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (slot_end) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign scl     = scl_oe_q ? 1'b0 : 1'bz;
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master with CLK_DIV=4: pull-ups on both lines, a responder at
// 7'h6B that ACKs its address, ACKs (or optionally NACKs) write data and
// returns a byte on reads, and a bus monitor that logs the bit seen at every
// SCL rise plus START/STOP conditions.
module tb_i2c_master;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        scl;
    wire        sda;

    pullup (scl);
    pullup (sda);

    logic resp_low = 1'b0;
    assign sda = resp_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master #(
        .CLK_DIV(D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rw     (rw),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .ack_err(ack_err),
        .scl    (scl),
        .sda    (sda)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Bus monitor / responder state
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         rise_cnt  = 0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         stop_rise = -1;
    logic       bit_log [32];
    logic [6:0] resp_addr = 7'h6B;
    logic [7:0] resp_rbyte = 8'h00;
    logic       resp_nack_data = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    function automatic logic [7:0] bus_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bit_log[base+i];
        return b;
    endfunction

    always @(negedge clk) begin : mon
        logic       cs, cd, match;
        logic [7:0] ab;
        int         r;
        cs = (scl !== 1'b0);
        cd = (sda !== 1'b0);
        if (prev_scl && cs && prev_sda && !cd) begin
            start_cnt++;
            rise_cnt = 0;
        end
        if (prev_scl && cs && !prev_sda && cd) begin
            stop_cnt++;
            stop_rise = rise_cnt;
        end
        if (!prev_scl && cs) begin
            if (rise_cnt < 32) bit_log[rise_cnt] = cd;
            rise_cnt++;
        end
        if (prev_scl && !cs) begin
            // Responder acts on each SCL fall, after the r-th rise of the frame.
            r     = rise_cnt;
            ab    = bus_byte(0);
            match = (r >= 8) && (ab[7:1] == resp_addr);
            resp_low = 1'b0;
            if (r == 8)
                resp_low = match;
            else if (match && ab[0] && r >= 9 && r <= 16)
                resp_low = !resp_rbyte[16-r];
            else if (match && !ab[0] && r == 17)
                resp_low = !resp_nack_data;
        end
        prev_scl = cs;
        prev_sda = cd;
    end

    task automatic clear_mon();
        start_cnt = 0;
        stop_cnt  = 0;
        rise_cnt  = 0;
        stop_rise = -1;
    endtask

    task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] w);
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = w;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (done !== 1'b1 && cyc < 2000);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_run++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got=%b exp=0", ack_err); end
        n_run++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        n_run++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl got=%b exp=1 (released)", scl); end
        n_run++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda got=%b exp=1 (released)", sda); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_write();
        int cyc;
        resp_nack_data = 1'b0;
        launch(1'b0, 7'h6B, 8'hA5);
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_rise got=%b exp=1", busy); end
        wait_done(cyc);
        n_run++; if (cyc != 80*D) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", cyc, 80*D); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_fall got=%b exp=0", busy); end
        n_run++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL wr_ack_err got=%b exp=0", ack_err); end
        n_run++; if (bus_byte(0) !== 8'hD6) begin n_fail++; $display("FAIL wr_addr_byte got=%h exp=d6", bus_byte(0)); end
        n_run++; if (bus_byte(9) !== 8'hA5) begin n_fail++; $display("FAIL wr_data_byte got=%h exp=a5", bus_byte(9)); end
        n_run++; if (bit_log[17] !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack got=%b exp=0", bit_log[17]); end
        n_run++; if (start_cnt != 1 || stop_cnt != 1) begin n_fail++; $display("FAIL wr_start_stop got=%0d/%0d exp=1/1", start_cnt, stop_cnt); end
        n_run++; if (stop_rise != 19) begin n_fail++; $display("FAIL wr_stop_pos got=%0d exp=19", stop_rise); end
        @(posedge clk); #1;
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL wr_done_width got=%b exp=0", done); end
    endtask

    task automatic test_read();
        int cyc;
        resp_rbyte = 8'h3C;
        exp_rdata  = 8'h3C;
        launch(1'b1, 7'h6B, 8'h00);
        wait_done(cyc);
        n_run++; if (cyc != 80*D) begin n_fail++; $display("FAIL rd_latency got=%0d exp=%0d", cyc, 80*D); end
        n_run++; if (bus_byte(0) !== 8'hD7) begin n_fail++; $display("FAIL rd_addr_byte got=%h exp=d7", bus_byte(0)); end
        n_run++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL rd_rdata got=%h exp=3c", rdata); end
        n_run++; if (bit_log[17] !== 1'b1) begin n_fail++; $display("FAIL rd_master_nack got=%b exp=1", bit_log[17]); end
        n_run++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL rd_ack_err got=%b exp=0", ack_err); end
        n_run++; if (stop_rise != 19 || stop_cnt != 1) begin n_fail++; $display("FAIL rd_stop got=%0d/%0d exp=19/1", stop_rise, stop_cnt); end
    endtask

    task automatic test_addr_nack();
        int cyc;
        launch(1'b0, 7'h12, 8'h77);
        wait_done(cyc);
        n_run++; if (cyc != 44*D) begin n_fail++; $display("FAIL nack_latency got=%0d exp=%0d", cyc, 44*D); end
        n_run++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL nack_ack_err got=%b exp=1", ack_err); end
        n_run++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL nack_rdata got=%h exp=%h", rdata, exp_rdata); end
        n_run++; if (bit_log[8] !== 1'b1) begin n_fail++; $display("FAIL nack_bit got=%b exp=1", bit_log[8]); end
        n_run++; if (stop_rise != 10 || stop_cnt != 1) begin n_fail++; $display("FAIL nack_stop got=%0d/%0d exp=10/1", stop_rise, stop_cnt); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        launch(1'b0, 7'h6B, 8'hA5);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 40) begin
                start = 1'b1; rw = 1'b1; addr = 7'h12; wdata = 8'h00;
            end else if (cyc == 41) begin
                start = 1'b0;
            end
        end while (done !== 1'b1 && cyc < 2000);
        n_run++; if (cyc != 80*D) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, 80*D); end
        n_run++; if (bus_byte(0) !== 8'hD6) begin n_fail++; $display("FAIL b2b_addr_kept got=%h exp=d6", bus_byte(0)); end
        n_run++; if (bus_byte(9) !== 8'hA5) begin n_fail++; $display("FAIL b2b_data_kept got=%h exp=a5", bus_byte(9)); end
        // Still inside the done cycle: this request must be dropped.
        clear_mon();
        start = 1'b1; rw = 1'b0; addr = 7'h6B; wdata = 8'h5A;
        @(posedge clk); #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cycle_start got busy=%b exp=0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_next_start got busy=%b exp=1", busy); end
        wait_done(cyc);
        n_run++; if (cyc != 80*D) begin n_fail++; $display("FAIL b2b2_latency got=%0d exp=%0d", cyc, 80*D); end
        n_run++; if (bus_byte(9) !== 8'h5A) begin n_fail++; $display("FAIL b2b2_data got=%h exp=5a", bus_byte(9)); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int guard;
        int seen;
        launch(1'b0, 7'h6B, 8'hA5);
        guard = 0;
        while (rise_cnt < 13 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        n_run++; if (rise_cnt < 13) begin n_fail++; $display("FAIL mid_reach_bit3 got rises=%0d exp>=13", rise_cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_run++; if (scl !== 1'b1) begin n_fail++; $display("FAIL mid_scl got=%b exp=1 (released)", scl); end
        n_run++; if (sda !== 1'b1) begin n_fail++; $display("FAIL mid_sda got=%b exp=1 (released)", sda); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(negedge clk) rst = 1'b0;
        exp_rdata = 8'h00;
        seen = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_run++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_done got=%0d pulses exp=0", seen); end
        n_run++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata got=%h exp=00", rdata); end
        launch(1'b0, 7'h6B, 8'h3C);
        wait_done(cyc);
        n_run++; if (cyc != 80*D) begin n_fail++; $display("FAIL mid_fresh_latency got=%0d exp=%0d", cyc, 80*D); end
        n_run++; if (bus_byte(9) !== 8'h3C) begin n_fail++; $display("FAIL mid_fresh_data got=%h exp=3c", bus_byte(9)); end
        n_run++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL mid_fresh_ack_err got=%b exp=0", ack_err); end
    endtask

    task automatic test_random();
        int         cyc;
        logic [6:0] a;
        logic [7:0] w;
        logic       r;
        logic       acked;
        logic       exp_err;
        int         exp_lat;
        int         exp_rises;
        for (int k = 0; k < 10; k++) begin
            a = ($urandom_range(0, 1) == 1) ? 7'h6B : 7'($urandom);
            r = 1'($urandom);
            w = 8'($urandom);
            resp_rbyte     = 8'($urandom);
            resp_nack_data = 1'($urandom);
            // Frame length: START + 8 addr + ACK [+ 8 data + ACK] + STOP
            acked     = (a == resp_addr);
            exp_lat   = acked ? 4 * D * 20 : 4 * D * 11;
            exp_rises = acked ? 19 : 10;
            exp_err   = !acked || (!r && resp_nack_data);
            if (acked && r) exp_rdata = resp_rbyte;
            launch(r, a, w);
            wait_done(cyc);
            n_run++; if (cyc != exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, cyc, exp_lat); end
            n_run++; if (ack_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_ack_err got=%b exp=%b", k, ack_err, exp_err); end
            n_run++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got=%h exp=%h", k, rdata, exp_rdata); end
            n_run++; if (bus_byte(0) !== {a, r}) begin n_fail++; $display("FAIL rnd%0d_addr_byte got=%h exp=%h", k, bus_byte(0), {a, r}); end
            n_run++; if (stop_rise != exp_rises) begin n_fail++; $display("FAIL rnd%0d_stop_pos got=%0d exp=%0d", k, stop_rise, exp_rises); end
            n_run++; if (start_cnt != 1 || stop_cnt != 1) begin n_fail++; $display("FAIL rnd%0d_start_stop got=%0d/%0d exp=1/1", k, start_cnt, stop_cnt); end
            if (acked && !r) begin
                n_run++; if (bus_byte(9) !== w) begin n_fail++; $display("FAIL rnd%0d_data_byte got=%h exp=%h", k, bus_byte(9), w); end
            end
            repeat ($urandom_range(1, 5)) @(posedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bit_log[i] = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/i2c_master.md
# i2c_master

Byte-oriented I2C bus controller that drives SCL and initiates single-byte write or read transactions to a 7-bit-addressed responder. It sits between on-chip control logic, which uses a start/busy/done handshake, and the open-drain I2C pins shared with responder devices such as the existing `i2c_slave`. SCL is derived from the system clock. Clock stretching and multi-byte bursts are out of scope.

## Interface
- `CLK_DIV`, default 250. Number of `clk` cycles per SCL quarter-period. Legal range is ≥2. One bit slot lasts 4*`CLK_DIV` cycles.
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `rw`  in  1  transfer direction, captured with `start`: 0 = write, 1 = read.
- `addr`  in  7  target address, captured with `start`.
- `wdata`  in  8  write byte, captured with `start`.
- `rdata`  out  8  byte received by the last read. Holds its value until the next read completes.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at transaction end.
- `ack_err`  out  1  valid with `done`. Set to 1 if any responder ACK was sampled high. Holds its value until the next `start` is accepted.
- `scl`  out  1  open-drain. Drives 0, otherwise `1'bz`.
- `sda`  inout  1  open-drain. Drives 0, otherwise `1'bz`. Read back through the pad.

## Operation
- Reset values:
  - `scl` and `sda` released (z).
  - `busy` = 0, `done` = 0, `ack_err` = 0, `rdata` = 8'h00.
  - FSM in IDLE, phase counter at 0.
- Reset taken mid-transaction releases both lines on the next edge. No STOP is generated.
- FSM states:
  - IDLE
  - START
  - ADDR: 8 bits, transmitted as {`addr`,`rw`}, MSB first.
  - ADDR_ACK
  - WRITE: 8 bits of `wdata`, MSB first.
  - WRITE_ACK
  - READ: 8 bits, MSB first.
  - READ_NACK
  - STOP
- Transitions:
  - IDLE→START on `start`.
  - START→ADDR.
  - ADDR_ACK→WRITE if `rw`=0, →READ if `rw`=1, →STOP if NACK.
  - WRITE→WRITE_ACK.
  - WRITE_ACK→STOP, ACK or NACK.
  - READ→READ_NACK→STOP.
  - STOP→IDLE, pulsing `done`.
- Bit slot phases (each `CLK_DIV` cycles):
  - P0: SCL low, SDA updated.
  - P1: SCL released.
  - P2: SCL high, SDA sampled at the first cycle of P2.
  - P3: SCL low.
- START slot: SDA high and SCL released in P0–P1, SDA pulled low in P2, SCL pulled low in P3.
- STOP slot: SDA low in P0, SCL released in P1, SDA released in P2.
- ACK slots: master releases SDA. Sampled 1 = NACK, which sets `ack_err`.
- READ_NACK: master releases SDA, sending NACK to end a single-byte read.
- READ bits: master releases SDA and shifts the sample into `rdata` MSB first. `rdata` updates only when READ_NACK is entered.
- `start` is ignored while `busy`. A `start` in the cycle `done` pulses is ignored; the next `start` is accepted one cycle later.

## Timing
- Transaction latency, from the accepting edge to the `done` edge, counted in bit slots (20 for write/read, 11 for address NACK):
  - Write or read: 20 bit slots → `done` at 80*`CLK_DIV` cycles.
  - Address NACK: 11 bit slots → `done` at 44*`CLK_DIV` cycles.
- SCL frequency = f_clk / (4*`CLK_DIV`). Duty cycle is 50%.
- SDA never changes while SCL is high, except in START and STOP slots.
- `busy` rises one cycle after the accepting edge and falls in the same cycle `done` pulses.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum.
  - Phase encoding P0..P3.
  - `I2C_RW_WRITE`=0, `I2C_RW_READ`=1.
  - `I2C_ACK`=0, `I2C_NACK`=1.
- Sub-module `i2c_bit_timer` holds the `CLK_DIV` quarter counter and 2-bit phase. It outputs `phase` and a `slot_end` strobe. It runs only while the FSM is not IDLE and clears on `rst`.
- Top level holds the FSM, the 3-bit bit counter, the shift register, and the open-drain drivers.

## Test plan
Run all scenarios with `CLK_DIV`=4 and a pull-up plus responder model on both lines.
- Write, `addr`=7'h6B, `rw`=0, `wdata`=8'hA5, responder ACKs → bus carries 8'hD6 then 8'hA5. `done` at cycle 320, `ack_err`=0, START/STOP edges legal.
- Read, `addr`=7'h6B, `rw`=1, responder returns 8'h3C → bus address byte 8'hD7, `rdata`=8'h3C, SDA released on the 9th data clock, `done` at cycle 320.
- No device at 7'h12 → NACK sampled, STOP follows immediately, `done` at cycle 176, `ack_err`=1, `rdata` unchanged.
- `start` pulsed while `busy`, and again in the `done` cycle → both ignored. `start` one cycle later is accepted.
- `rst` asserted during the WRITE bit 3 slot → next edge: `scl`/`sda` = z, `busy`=0, `done` never pulses. A fresh write then completes normally.
